// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, flush and back-pressure.
// Keeps saturating counters of inserted bubbles and of flushes that hit a
// valid instruction.
//
// Handshake: the EX register takes a new instruction on a clock edge only when
// ex_ready=1 and flush_i=0. When that holds and there is no load-use hazard,
// decode advances. stall_o tells fetch/decode to hold the IF/ID register.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic [2:0]      id_valid_reg,
    input  logic [1:0]      id_alu_op,
    input  logic [1:0]      id_reg_src,
    input  logic [6:0]      id_ctrl,
    input  logic            flush_i,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic [1:0]      ex_alu_op,
    output logic [1:0]      ex_reg_src,
    output logic [6:0]      ex_ctrl,
    output logic            stall_o,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Bit position of MemRead inside {ALUSrc,RegWrite,MemRead,MemWrite,Branch,Jump,ZeroOp}
    localparam int CTRL_MEMREAD = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            funct7b5_q, funct7b5_d;
    logic [1:0]      alu_op_q, alu_op_d, reg_src_q, reg_src_d;
    logic [6:0]      ctrl_q, ctrl_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
    logic            load_use;
    logic            rs1_hit, rs2_hit;

    // Hazard: the load in EX writes a register that the instruction in ID reads.
    always_comb begin
        rs1_hit  = id_valid_reg[1] && (id_rs1 == rd_q);
        rs2_hit  = id_valid_reg[2] && (id_rs2 == rd_q);
        load_use = valid_q && ctrl_q[CTRL_MEMREAD] && (rd_q != 5'd0) && id_valid
                   && (rs1_hit || rs2_hit);
        stall_o  = !flush_i && (load_use || !ex_ready);
    end

    // Next state of the EX register: flush beats back-pressure beats bubble beats load.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        alu_op_d   = alu_op_q;
        reg_src_d  = reg_src_q;
        ctrl_d     = ctrl_q;
        if (flush_i || (ex_ready && load_use)) begin
            // Kill or bubble: only validity and control are cleared, data is left alone.
            valid_d   = 1'b0;
            ctrl_d    = 7'd0;
            alu_op_d  = 2'd0;
            reg_src_d = 2'd0;
        end else if (ex_ready) begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_valid_reg[1] ? id_rs1 : 5'd0;
            rs2_d      = id_valid_reg[2] ? id_rs2 : 5'd0;
            rd_d       = id_valid_reg[0] ? id_rd  : 5'd0;
            funct3_d   = id_funct3;
            funct7b5_d = id_funct7b5;
            alu_op_d   = id_valid ? id_alu_op  : 2'd0;
            reg_src_d  = id_valid ? id_reg_src : 2'd0;
            ctrl_d     = id_valid ? id_ctrl    : 7'd0;
        end
    end

    // Saturating event counters.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (flush_i && id_valid && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (!flush_i && ex_ready && load_use && (bubble_cnt_q != CNT_MAX))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            funct3_q     <= 3'd0;
            funct7b5_q   <= 1'b0;
            alu_op_q     <= 2'd0;
            reg_src_q    <= 2'd0;
            ctrl_q       <= 7'd0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs1_data_q   <= rs1_data_d;
            rs2_data_q   <= rs2_data_d;
            imm_q        <= imm_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            funct3_q     <= funct3_d;
            funct7b5_q   <= funct7b5_d;
            alu_op_q     <= alu_op_d;
            reg_src_q    <= reg_src_d;
            ctrl_q       <= ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct3   = funct3_q;
    assign ex_funct7b5 = funct7b5_q;
    assign ex_alu_op   = alu_op_q;
    assign ex_reg_src  = reg_src_q;
    assign ex_ctrl     = ctrl_q;
    assign bubble_cnt  = bubble_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized run, all checked
// against a small behavioural model of the EX register and counters.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam int CMAX  = 3;
    localparam int VW    = 4*XLEN + 31;
    localparam logic [6:0] C_LW  = 7'b1110000;
    localparam logic [6:0] C_ADD = 7'b0100000;
    localparam logic [6:0] C_LUI = 7'b1100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0;
    logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [2:0] id_funct3 = '0;
    logic id_funct7b5 = 1'b0;
    logic [2:0] id_valid_reg = '0;
    logic [1:0] id_alu_op = '0, id_reg_src = '0;
    logic [6:0] id_ctrl = '0;
    logic flush_i = 1'b0, ex_ready = 1'b1;

    logic ex_valid, ex_funct7b5, stall_o;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0] ex_funct3;
    logic [1:0] ex_alu_op, ex_reg_src;
    logic [6:0] ex_ctrl;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_valid_reg(id_valid_reg), .id_alu_op(id_alu_op),
        .id_reg_src(id_reg_src), .id_ctrl(id_ctrl), .flush_i(flush_i), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_alu_op(ex_alu_op), .ex_reg_src(ex_reg_src), .ex_ctrl(ex_ctrl),
        .stall_o(stall_o), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    wire [VW-1:0] ex_vec = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                            ex_rd, ex_funct3, ex_funct7b5, ex_alu_op, ex_reg_src, ex_ctrl};

    // ---------------- reference model ----------------
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_r1d, m_r2d, m_imm;
    logic [4:0]      m_rs1, m_rs2, m_rd;
    logic [2:0]      m_f3;
    logic            m_f7;
    logic [1:0]      m_aop, m_rsrc;
    logic [6:0]      m_ctrl;
    int              m_bub, m_fl;

    function automatic logic [VW-1:0] exp_vec();
        return {m_valid, m_pc, m_r1d, m_r2d, m_imm, m_rs1, m_rs2, m_rd, m_f3, m_f7,
                m_aop, m_rsrc, m_ctrl};
    endfunction

    // Does the instruction in ID read the register a load in EX is about to produce?
    function automatic bit exp_hazard();
        bit is_load, reads;
        is_load = m_valid && m_ctrl[4] && (m_rd != 0);
        reads   = (id_valid_reg[1] && id_rs1 == m_rd) || (id_valid_reg[2] && id_rs2 == m_rd);
        return is_load && id_valid && reads;
    endfunction

    function automatic bit exp_stall();
        return !flush_i && (exp_hazard() || !ex_ready);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = '0; m_r1d = '0; m_r2d = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = 0;
        m_aop = '0; m_rsrc = '0; m_ctrl = '0; m_bub = 0; m_fl = 0;
    endtask

    task automatic model_edge();
        bit hz;
        hz = exp_hazard();
        if (flush_i) begin
            m_valid = 0; m_ctrl = '0; m_aop = '0; m_rsrc = '0;
            if (id_valid && m_fl < CMAX) m_fl++;
        end else if (!ex_ready) begin
            // nothing moves
        end else if (hz) begin
            m_valid = 0; m_ctrl = '0; m_aop = '0; m_rsrc = '0;
            if (m_bub < CMAX) m_bub++;
        end else begin
            m_valid = id_valid;
            m_pc = id_pc; m_r1d = id_rs1_data; m_r2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_valid_reg[1] ? id_rs1 : 5'd0;
            m_rs2 = id_valid_reg[2] ? id_rs2 : 5'd0;
            m_rd  = id_valid_reg[0] ? id_rd  : 5'd0;
            m_f3 = id_funct3; m_f7 = id_funct7b5;
            m_aop  = id_valid ? id_alu_op  : 2'd0;
            m_rsrc = id_valid ? id_reg_src : 2'd0;
            m_ctrl = id_valid ? id_ctrl    : 7'd0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [2:0] vr, input logic [6:0] ctrl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_valid_reg = vr; id_ctrl = ctrl;
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_funct3 = 3'($urandom_range(0, 7)); id_funct7b5 = 1'($urandom_range(0, 1));
        id_alu_op = 2'($urandom_range(0, 3)); id_reg_src = 2'($urandom_range(0, 3));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 0; flush_i = 0; ex_ready = 1;
        set_id(1, 1, 2, 3, 3'b111, C_ADD);
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (ex_vec !== '0) begin errors++; $display("FAIL reset_regs: got %h exp 0", ex_vec); end
        checks++;
        if (bubble_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", bubble_cnt, flush_cnt);
        end
        set_id(0, 0, 0, 0, 3'b000, 7'd0);
        @(negedge clk); rst_n = 1;
        #1;
        cycle();
    endtask

    task automatic test_stream();
        set_id(1, 1, 2, 3, 3'b111, C_ADD);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL stream_stall: got %b exp 0", stall_o); end
        cycle();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_ctrl[5] !== 1'b1) begin
            errors++; $display("FAIL stream_add: got v=%b rd=%0d ctrl=%b exp v=1 rd=3 RegWrite=1",
                               ex_valid, ex_rd, ex_ctrl);
        end
        checks++;
        if (ex_vec !== exp_vec()) begin errors++; $display("FAIL stream_vec: got %h exp %h", ex_vec, exp_vec()); end
    endtask

    task automatic test_load_use();
        set_id(1, 1, 0, 5, 3'b011, C_LW);
        cycle();
        set_id(1, 5, 6, 7, 3'b111, C_ADD);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b exp 1", stall_o); end
        cycle();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 7'd0 || bubble_cnt !== 2'd1) begin
            errors++; $display("FAIL lu_bubble: got v=%b ctrl=%b bub=%0d exp v=0 ctrl=0 bub=1",
                               ex_valid, ex_ctrl, bubble_cnt);
        end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_unstall: got %b exp 0", stall_o); end
        cycle();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_vec !== exp_vec()) begin
            errors++; $display("FAIL lu_enter: got v=%b rs1=%0d exp v=1 rs1=5", ex_valid, ex_rs1);
        end
    endtask

    task automatic test_no_false_hazard();
        set_id(1, 1, 0, 0, 3'b011, C_LW);
        cycle();
        set_id(1, 0, 0, 4, 3'b111, C_ADD);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL nf_x0: got %b exp 0", stall_o); end
        cycle();
        set_id(1, 2, 0, 5, 3'b011, C_LW);
        cycle();
        set_id(1, 5, 5, 8, 3'b001, C_LUI);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL nf_lui: got %b exp 0", stall_o); end
        cycle();
        checks++;
        if (bubble_cnt !== 2'd1 || ex_vec !== exp_vec()) begin
            errors++; $display("FAIL nf_cnt: got bub=%0d exp 1", bubble_cnt);
        end
    endtask

    task automatic test_flush_hold();
        logic [VW-1:0] saved;
        set_id(1, 1, 2, 9, 3'b111, C_ADD);
        cycle();
        set_id(1, 3, 4, 11, 3'b111, C_ADD);
        ex_ready = 0; flush_i = 1;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b exp 0", stall_o); end
        cycle();
        checks++;
        if (ex_valid !== 1'b0 || flush_cnt !== 2'd1 || ex_vec !== exp_vec()) begin
            errors++; $display("FAIL fl_kill: got v=%b fl=%0d exp v=0 fl=1", ex_valid, flush_cnt);
        end
        flush_i = 0; ex_ready = 1;
        set_id(1, 1, 2, 10, 3'b111, C_ADD);
        cycle();
        ex_ready = 0;
        set_id(1, 6, 7, 12, 3'b111, C_ADD);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL hold_stall: got %b exp 1", stall_o); end
        saved = exp_vec();
        cycle();
        checks++;
        if (ex_vec !== saved) begin errors++; $display("FAIL hold_regs: got %h exp %h", ex_vec, saved); end
        ex_ready = 1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            set_id(1, 1, 0, 5, 3'b011, C_LW);
            cycle();
            set_id(1, 2, 5, 6, 3'b111, C_ADD);
            cycle();
            cycle();
        end
        checks++;
        if (bubble_cnt !== 2'd3) begin errors++; $display("FAIL sat_bub: got %0d exp 3", bubble_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0) ? C_LW : 7'($urandom_range(0, 127)));
            ex_ready = ($urandom_range(0, 4) != 0);
            flush_i  = ($urandom_range(0, 9) == 0);
            #1;
            checks++;
            if (stall_o !== exp_stall()) begin
                errors++; $display("FAIL rnd_stall[%0d]: got %b exp %b", i, stall_o, exp_stall());
            end
            cycle();
            checks++;
            if (ex_vec !== exp_vec() || bubble_cnt !== CNT_W'(m_bub) || flush_cnt !== CNT_W'(m_fl)) begin
                errors++; $display("FAIL rnd_regs[%0d]: got %h b%0d f%0d exp %h b%0d f%0d",
                                   i, ex_vec, bubble_cnt, flush_cnt, exp_vec(), m_bub, m_fl);
            end
        end
        flush_i = 0; ex_ready = 1;
    endtask

    task automatic test_async_reset();
        set_id(1, 1, 0, 5, 3'b011, C_LW);
        cycle();
        set_id(1, 5, 0, 7, 3'b111, C_ADD);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL ar_stall: got %b exp 1", stall_o); end
        #1 rst_n = 0;
        model_reset();
        #1;
        checks++;
        if (ex_vec !== '0 || bubble_cnt !== '0 || flush_cnt !== '0) begin
            errors++; $display("FAIL ar_clear: got %h b%0d f%0d exp 0", ex_vec, bubble_cnt, flush_cnt);
        end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL ar_unstall: got %b exp 0", stall_o); end
        @(negedge clk); rst_n = 1;
        #1;
        cycle();
        checks++;
        if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_vec !== exp_vec()) begin
            errors++; $display("FAIL ar_resume: got v=%b rs1=%0d exp v=1 rs1=5", ex_valid, ex_rs1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_load_use();
        test_no_false_hazard();
        test_flush_hold();
        test_saturation();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
